// File: rtl/shared_reg_arb_pkg.sv
// rtl/shared_reg_arb_pkg.sv - state type and width helpers for shared_reg_arbiter
package shared_reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Width of a requester index (at least one bit).
    function automatic int idx_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Width of the hold counter, which counts down from HOLD-1 to 0.
    function automatic int cnt_width(input int hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rtl/shared_reg_arbiter_rr_pick.sv - combinational round-robin picker starting at rr_ptr
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   winner,
    output logic            any
);

    // Scan offsets from farthest to nearest so the first requester at or after rr_ptr wins.
    always_comb begin
        logic [IW-1:0] w_idx;
        winner = '0;
        any    = |req;
        w_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (req[w_idx]) begin
                winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin arbiter for one shared capture register; optional SHARED_REG_ARB_LOCK_EN
module shared_reg_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 3,
    parameter int HOLD = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] data,
`ifdef SHARED_REG_ARB_LOCK_EN
    input  logic              lock,
`endif
    output logic [NREQ-1:0]   ack,
    output logic [DW-1:0]     z,
    output logic              upd,
    output logic [DW:0]       res,
    output logic              busy
);
    import shared_reg_arb_pkg::*;

    localparam int IW = idx_width(NREQ);
    localparam int CW = cnt_width(HOLD);
    localparam logic [CW-1:0] HOLD_INIT = CW'((HOLD > 0) ? HOLD - 1 : 0);

    state_t          r_state;
    state_t          w_next_state;
    logic [IW-1:0]   r_gnt_idx;
    logic [IW-1:0]   r_rr_ptr;
    logic [CW-1:0]   r_hold_cnt;
    logic [DW-1:0]   r_z;
    logic            r_upd;
    logic            r_locked;

    logic [IW-1:0]   w_winner;
    logic            w_any;
    logic            w_capture;
    logic            w_lock;
    logic [IW-1:0]   w_next_ptr;
    logic [DW-1:0]   w_words [NREQ];
    logic [NREQ-1:0] w_ack;

`ifdef SHARED_REG_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    // Unpack the flat data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_words[i] = data[i*DW +: DW];
        end
    end

    // A capture happens only if the granted requester is still asking in the GRANT cycle.
    assign w_capture  = (r_state == GRANT) && req[r_gnt_idx];
    assign w_next_ptr = (r_gnt_idx == IW'(NREQ - 1)) ? '0 : r_gnt_idx + IW'(1);

    // Ack index comes from registers only; req merely gates the granted bit.
    always_comb begin
        w_ack = '0;
        if (r_state == GRANT) begin
            w_ack[r_gnt_idx] = req[r_gnt_idx];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: arbitrate, grant, then hold (or re-grant when locked).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next_state = GRANT;
                end
            end
            GRANT: begin
                if (!w_capture) begin
                    w_next_state = IDLE;
                end else if (HOLD > 0) begin
                    w_next_state = shared_reg_arb_pkg::HOLD;
                end else if (w_lock) begin
                    w_next_state = GRANT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            shared_reg_arb_pkg::HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_next_state = r_locked ? GRANT : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Grant index, pointer, hold counter, shared register and update pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_idx  <= '0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_z        <= '0;
            r_upd      <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (r_state == IDLE && w_any) begin
                r_gnt_idx <= w_winner;
            end
            if (w_capture) begin
                r_z        <= w_words[r_gnt_idx];
                r_upd      <= 1'b1;
                r_hold_cnt <= HOLD_INIT;
                r_locked   <= w_lock;
                if (!w_lock) begin
                    r_rr_ptr <= w_next_ptr;
                end
            end else if (r_state == shared_reg_arb_pkg::HOLD && r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - CW'(1);
            end
        end
    end

    assign ack  = w_ack;
    assign z    = r_z;
    assign upd  = r_upd;
    assign res  = {r_upd, r_z};
    assign busy = (r_state != IDLE);

endmodule
